// File: rtl/neuron_bank_rotator.sv
// -----------------------------------------------------------------------------
// neuron_bank_rotator
//
// Manages a ring of BANKS neuron buffer banks. One bank is the read bank. It
// feeds the conv unit and the host IO port. The next bank in the ring is the
// write bank. It takes pool-unit rows and supplies the conv unit's partial
// sums. At a layer boundary the roles rotate one step around the ring. The
// rotation runs through a drain/commit handshake, so an in-flight pool row
// always lands in the bank that was the write bank when the row was accepted.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   swap_req       level request to rotate roles, held until swap_ack
//   swap_ack       one-cycle pulse in the cycle the rotation commits
//   busy           high while draining or committing
//   rd_bank        current read bank index
//   wr_bank        current write bank index, (rd_bank+1) mod BANKS
//   swap_count     committed rotations, wraps 255 -> 0
//   rd_addr        read-side row address
//   wr_addr        write-side row address, sampled together with pool_valid
//   bank_addr      per-bank row address, bank k in slice k
//   bank_rd_data   per-bank row read data
//   bank_wr_data   per-bank row write data
//   bank_wr_en     per-bank write strobe
//   pool_data      pool-unit output row
//   pool_valid     pool row valid
//   pool_ready     pool row accepted when pool_valid & pool_ready
//   conv_nbuff     read bank row to the conv unit
//   conv_psum      write bank row to the conv unit (partial sums)
//   io_in          host IO command/data
//   io_in_bank     io_in routed to the read bank, other slices zero
//   io_out_bank    per-bank IO read data
//   io_out         registered IO read data of the read bank
// -----------------------------------------------------------------------------
module neuron_bank_rotator #(
    parameter int BANKS = 2,
    parameter int depth = 2,
    parameter int D     = 1 << depth,
    parameter int W     = 16,
    parameter int A     = 7,
    parameter int BI    = (BANKS > 2) ? 2 : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        swap_req,
    output logic                        swap_ack,
    output logic                        busy,
    output logic [BI-1:0]               rd_bank,
    output logic [BI-1:0]               wr_bank,
    output logic [7:0]                  swap_count,

    input  logic [A-1:0]                rd_addr,
    input  logic [A-1:0]                wr_addr,
    output logic [BANKS*A-1:0]          bank_addr,
    input  logic [BANKS*W*D-1:0]        bank_rd_data,
    output logic [BANKS*W*D-1:0]        bank_wr_data,
    output logic [BANKS-1:0]            bank_wr_en,

    input  logic [W*D-1:0]              pool_data,
    input  logic                        pool_valid,
    output logic                        pool_ready,

    output logic [W*D-1:0]              conv_nbuff,
    output logic [W*D-1:0]              conv_psum,

    input  logic [W+depth+1:0]          io_in,
    output logic [BANKS*(W+depth+2)-1:0] io_in_bank,
    input  logic [BANKS*W-1:0]          io_out_bank,
    output logic [W-1:0]                io_out
);

    localparam int RW  = W * D;          // row width
    localparam int IOW = W + depth + 2;  // IO command width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic          accept;
    logic          stage_valid;
    logic [RW-1:0] stage_data;
    logic [A-1:0]  stage_addr;
    logic [BI-1:0] stage_bank;
    logic [W-1:0]  io_sel;

    // Rows are only taken in IDLE, so acceptance depends on state alone.
    assign accept  = pool_valid && (state == IDLE);
    assign wr_bank = (rd_bank == BI'(BANKS - 1)) ? '0 : rd_bank + BI'(1);

    // ------------------------------------------------------------------
    // Swap FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        pool_ready = 1'b0;
        swap_ack   = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                pool_ready = 1'b1;
                if (swap_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // A row held in the stage is written on the edge that ends
                // this cycle. The stage is empty after that edge unless a new
                // row is accepted now, and no row can be accepted outside IDLE.
                if (!accept) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                busy      = 1'b1;
                swap_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Role rotation and swap counter advance on the edge that ends COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank    <= '0;
            swap_count <= '0;
        end else if (state == COMMIT) begin
            rd_bank    <= wr_bank;
            swap_count <= swap_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Write stage: one register deep
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
        end else begin
            stage_valid <= accept;
        end
    end

    // NOTE: the payload needs no reset. Every use of it is gated by
    // stage_valid, and resetting wide data only adds reset routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            stage_data <= pool_data;
            stage_addr <= wr_addr;
            stage_bank <= wr_bank;
        end
    end

    // ------------------------------------------------------------------
    // Bank routing: addresses, conv rows, IO, write strobes
    // ------------------------------------------------------------------
    always_comb begin
        bank_addr    = '0;
        bank_wr_data = '0;
        bank_wr_en   = '0;
        io_in_bank   = '0;
        conv_nbuff   = '0;
        conv_psum    = '0;
        io_sel       = '0;
        for (int k = 0; k < BANKS; k++) begin
            if (BI'(k) == rd_bank) begin
                bank_addr[k*A +: A]      = rd_addr;
                conv_nbuff               = bank_rd_data[k*RW +: RW];
                io_in_bank[k*IOW +: IOW] = io_in;
                io_sel                   = io_out_bank[k*W +: W];
            end
            if (BI'(k) == wr_bank) begin
                bank_addr[k*A +: A] = stage_valid ? stage_addr : wr_addr;
                conv_psum           = bank_rd_data[k*RW +: RW];
            end
            if (stage_valid && (BI'(k) == stage_bank)) begin
                bank_wr_en[k]             = 1'b1;
                bank_wr_data[k*RW +: RW]  = stage_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_out <= '0;
        end else begin
            io_out <= io_sel;
        end
    end

endmodule

// File: tb/tb_neuron_bank_rotator.sv
// -----------------------------------------------------------------------------
// tb_neuron_bank_rotator
//
// Runs a two-bank and a three-bank rotator side by side on shared stimulus.
// Pool writes into the three-bank instance are predicted into a queue when
// they are driven and retired when a write strobe appears.
// -----------------------------------------------------------------------------
module tb_neuron_bank_rotator;

    localparam int W   = 16;
    localparam int DP  = 2;
    localparam int D   = 1 << DP;
    localparam int A   = 7;
    localparam int RW  = W * D;
    localparam int IOW = W + DP + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic swap_req;
    logic pool_valid;
    logic [A-1:0]   rd_addr;
    logic [A-1:0]   wr_addr;
    logic [RW-1:0]  pool_data;
    logic [IOW-1:0] io_in;

    // two-bank instance
    logic           swap_ack2, busy2, pool_ready2;
    logic [0:0]     rd_bank2, wr_bank2;
    logic [7:0]     swap_count2;
    logic [2*A-1:0] bank_addr2;
    logic [2*RW-1:0] bank_rd_data2, bank_wr_data2;
    logic [1:0]     bank_wr_en2;
    logic [RW-1:0]  conv_nbuff2, conv_psum2;
    logic [2*IOW-1:0] io_in_bank2;
    logic [2*W-1:0] io_out_bank2;
    logic [W-1:0]   io_out2;

    // three-bank instance
    logic           swap_ack3, busy3, pool_ready3;
    logic [1:0]     rd_bank3, wr_bank3;
    logic [7:0]     swap_count3;
    logic [3*A-1:0] bank_addr3;
    logic [3*RW-1:0] bank_rd_data3, bank_wr_data3;
    logic [2:0]     bank_wr_en3;
    logic [RW-1:0]  conv_nbuff3, conv_psum3;
    logic [3*IOW-1:0] io_in_bank3;
    logic [3*W-1:0] io_out_bank3;
    logic [W-1:0]   io_out3;

    logic [RW-1:0] rd_pat2 [2] = '{64'h0101_0202_0303_0404, 64'h1010_2020_3030_4040};
    logic [RW-1:0] rd_pat3 [3] = '{64'hAAAA_0000_AAAA_0001, 64'hBBBB_0000_BBBB_0002,
                                   64'hCCCC_0000_CCCC_0003};
    logic [W-1:0]  io_pat2 [2];
    logic [W-1:0]  io_pat3 [3];

    assign bank_rd_data2 = {rd_pat2[1], rd_pat2[0]};
    assign bank_rd_data3 = {rd_pat3[2], rd_pat3[1], rd_pat3[0]};
    assign io_out_bank2  = {io_pat2[1], io_pat2[0]};
    assign io_out_bank3  = {io_pat3[2], io_pat3[1], io_pat3[0]};

    neuron_bank_rotator #(.BANKS(2), .depth(DP), .W(W), .A(A)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .swap_req(swap_req), .swap_ack(swap_ack2), .busy(busy2),
        .rd_bank(rd_bank2), .wr_bank(wr_bank2), .swap_count(swap_count2),
        .rd_addr(rd_addr), .wr_addr(wr_addr), .bank_addr(bank_addr2),
        .bank_rd_data(bank_rd_data2), .bank_wr_data(bank_wr_data2), .bank_wr_en(bank_wr_en2),
        .pool_data(pool_data), .pool_valid(pool_valid), .pool_ready(pool_ready2),
        .conv_nbuff(conv_nbuff2), .conv_psum(conv_psum2),
        .io_in(io_in), .io_in_bank(io_in_bank2), .io_out_bank(io_out_bank2), .io_out(io_out2)
    );

    neuron_bank_rotator #(.BANKS(3), .depth(DP), .W(W), .A(A)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .swap_req(swap_req), .swap_ack(swap_ack3), .busy(busy3),
        .rd_bank(rd_bank3), .wr_bank(wr_bank3), .swap_count(swap_count3),
        .rd_addr(rd_addr), .wr_addr(wr_addr), .bank_addr(bank_addr3),
        .bank_rd_data(bank_rd_data3), .bank_wr_data(bank_wr_data3), .bank_wr_en(bank_wr_en3),
        .pool_data(pool_data), .pool_valid(pool_valid), .pool_ready(pool_ready3),
        .conv_nbuff(conv_nbuff3), .conv_psum(conv_psum3),
        .io_in(io_in), .io_in_bank(io_in_bank3), .io_out_bank(io_out_bank3), .io_out(io_out3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_rd2 = 0;
    int exp_rd3 = 0;
    int exp_swaps = 0;

    typedef struct {
        int           bank;
        logic [A-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    wr_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Retire predicted writes on the three-bank instance.
    always @(negedge clk) begin
        if (rst_n && bank_wr_en3 != 3'b000) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", 64'(bank_wr_en3), 64'd0);
            end else begin : retire
                wr_t e;
                e = sb_q.pop_front();
                check("sb_wr_en", 64'(bank_wr_en3), 64'(3'b001 << e.bank));
                check("sb_wr_data", bank_wr_data3[e.bank*RW +: RW], e.data);
                check("sb_wr_addr", 64'(bank_addr3[e.bank*A +: A]), 64'(e.addr));
            end
        end
    end

    // Drive one pool row for one cycle; returns #1 after the accepting edge.
    task automatic pool_write(input logic [A-1:0] addr, input logic [RW-1:0] data);
        @(posedge clk) #1;
        pool_valid = 1'b1;
        wr_addr    = addr;
        pool_data  = data;
        sb_q.push_back('{(exp_rd3 + 1) % 3, addr, data});
        @(posedge clk) #1;
        pool_valid = 1'b0;
        wr_addr    = ~addr;  // the write must use the captured address
    endtask

    // Request one rotation, optionally with a row arriving in the same cycle.
    task automatic do_swap(input bit with_write, input logic [RW-1:0] data);
        int acks2 = 0, acks3 = 0, ack_cyc = -1, nready = 0;
        logic [1:0] en2_seen = 2'b00;
        logic [1:0] en2_exp;
        en2_exp = with_write ? (2'b01 << ((exp_rd2 + 1) % 2)) : 2'b00;
        @(posedge clk) #1;
        swap_req = 1'b1;
        if (with_write) begin
            pool_valid = 1'b1;
            wr_addr    = 7'd3;
            pool_data  = data;
            sb_q.push_back('{(exp_rd3 + 1) % 3, 7'd3, data});
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(posedge clk) #1;
                pool_valid = 1'b0;
                if (acks2 > 0) swap_req = 1'b0;
            end
            @(negedge clk);
            if (!pool_ready2) nready++;
            if (swap_ack2) begin
                acks2++;
                if (ack_cyc < 0) ack_cyc = c;
            end
            if (swap_ack3) acks3++;
            en2_seen |= bank_wr_en2;
        end
        swap_req = 1'b0;
        exp_rd2   = (exp_rd2 + 1) % 2;
        exp_rd3   = (exp_rd3 + 1) % 3;
        exp_swaps = exp_swaps + 1;
        check("swap_ack2_count", 64'(acks2), 64'd1);
        check("swap_ack3_count", 64'(acks3), 64'd1);
        check("swap_ack_cycle", 64'(ack_cyc), 64'd2);
        check("pool_ready_low_cycles", 64'(nready), 64'd2);
        check("swap_wr_en2", 64'(en2_seen), 64'(en2_exp));
        check("rd_bank2", 64'(rd_bank2), 64'(exp_rd2));
        check("wr_bank2", 64'(wr_bank2), 64'((exp_rd2 + 1) % 2));
        check("rd_bank3", 64'(rd_bank3), 64'(exp_rd3));
        check("wr_bank3", 64'(wr_bank3), 64'((exp_rd3 + 1) % 3));
        check("swap_count3", 64'(swap_count3), 64'(exp_swaps));
        check("conv_nbuff3", conv_nbuff3, rd_pat3[exp_rd3]);
        check("conv_psum3", conv_psum3, rd_pat3[(exp_rd3 + 1) % 3]);
        check("conv_psum2", conv_psum2, rd_pat2[(exp_rd2 + 1) % 2]);
    endtask

    initial begin : main
        logic [3*IOW-1:0] io3_exp;
        logic [2*IOW-1:0] io2_exp;
        int acks;

        io_pat2 = '{16'h1234, 16'hBEEF};
        io_pat3 = '{16'h1111, 16'h2222, 16'h3333};
        rst_n      = 1'b0;
        swap_req   = 1'b0;
        pool_valid = 1'b0;
        pool_data  = '0;
        rd_addr    = 7'h11;
        wr_addr    = 7'h22;
        io_in      = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rd_bank2", 64'(rd_bank2), 64'd0);
        check("rst_wr_bank2", 64'(wr_bank2), 64'd1);
        check("rst_rd_bank3", 64'(rd_bank3), 64'd0);
        check("rst_wr_bank3", 64'(wr_bank3), 64'd1);
        check("rst_swap_count", 64'(swap_count3), 64'd0);
        check("rst_swap_ack", 64'({swap_ack2, swap_ack3}), 64'd0);
        check("rst_busy", 64'({busy2, busy3}), 64'd0);
        check("rst_pool_ready", 64'({pool_ready2, pool_ready3}), 64'd3);
        check("rst_bank_wr_en", 64'({bank_wr_en2, bank_wr_en3}), 64'd0);
        check("rst_bank_wr_data", 64'(|{bank_wr_data2, bank_wr_data3}), 64'd0);
        check("rst_io_out", 64'({io_out2, io_out3}), 64'd0);
        check("rst_addr2_s0", 64'(bank_addr2[6:0]), 64'h11);
        check("rst_addr2_s1", 64'(bank_addr2[13:7]), 64'h22);
        check("rst_addr3_s2", 64'(bank_addr3[20:14]), 64'd0);

        @(posedge clk) #1;
        rst_n = 1'b1;

        // Write routing into the write bank
        pool_write(7'd5, 64'h1111_2222_3333_4444);
        check("wr_en2", 64'(bank_wr_en2), 64'd2);
        check("wr_data2_s1", bank_wr_data2[2*RW-1:RW], 64'h1111_2222_3333_4444);
        check("wr_data2_s0", bank_wr_data2[RW-1:0], 64'd0);
        check("wr_addr2_s1", 64'(bank_addr2[13:7]), 64'd5);
        check("rd_addr2_s0", 64'(bank_addr2[6:0]), 64'h11);
        @(posedge clk) #1;
        check("wr_en2_oneshot", 64'(bank_wr_en2), 64'd0);

        // Swap with a row arriving alongside the request, then ring wrap
        do_swap(1'b1, 64'hDEAD_BEEF_0BAD_F00D);
        do_swap(1'b0, '0);
        pool_write(7'd9, 64'h5555_6666_7777_8888);  // rd3=2: lands in bank 0
        do_swap(1'b0, '0);

        // IO path
        @(posedge clk) #1;
        io_in = 20'hABCDE;
        @(posedge clk) #1;
        check("io_out3", 64'(io_out3), 64'(io_pat3[exp_rd3]));
        check("io_out2", 64'(io_out2), 64'(io_pat2[exp_rd2]));
        io3_exp = '0;
        io3_exp[exp_rd3*IOW +: IOW] = io_in;
        io2_exp = '0;
        io2_exp[exp_rd2*IOW +: IOW] = io_in;
        check("io_in_bank3", 64'(io3_exp), 64'(io_in_bank3));
        check("io_in_bank2", 64'(io2_exp), 64'(io_in_bank2));
        io_pat3[exp_rd3] = 16'h7E57;
        @(negedge clk);
        check("io_out3_latency_old", 64'(io_out3), 64'(io_pat3[(exp_rd3 + 1) % 3] == 16'h0 ? 16'h0 : 16'h1111));
        @(posedge clk) #1;
        check("io_out3_latency_new", 64'(io_out3), 64'h7E57);

        // Reset while draining with a row in flight
        @(posedge clk) #1;
        swap_req   = 1'b1;
        pool_valid = 1'b1;
        pool_data  = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk) #1;
        check("drain_busy", 64'(busy3), 64'd1);
        rst_n      = 1'b0;
        swap_req   = 1'b0;
        pool_valid = 1'b0;
        #1;
        check("drain_rst_wr_en", 64'({bank_wr_en2, bank_wr_en3}), 64'd0);
        check("drain_rst_busy", 64'({busy2, busy3}), 64'd0);
        check("drain_rst_rd_bank", 64'({rd_bank2, rd_bank3}), 64'd0);
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            acks += int'(swap_ack3) + int'(swap_ack2);
        end
        @(posedge clk) #1;
        rst_n   = 1'b1;
        exp_rd2 = 0;
        exp_rd3 = 0;
        repeat (3) begin
            @(negedge clk);
            acks += int'(swap_ack3) + int'(swap_ack2);
        end
        check("drain_rst_no_ack", 64'(acks), 64'd0);
        check("drain_rst_count", 64'(swap_count3), 64'd0);
        check("drain_rst_wr_bank3", 64'(wr_bank3), 64'd1);
        check("drain_rst_nbuff3", conv_nbuff3, rd_pat3[exp_rd3]);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
